// File: rtl/ssp_host_pkg.sv
// ssp_host_pkg: shared state, byte and counter types for the SSP host
package ssp_host_pkg;
    typedef enum logic [1:0] {IDLE, WRITE, READ} state_t;
    typedef logic [7:0]  byte_t;
    typedef logic [15:0] count_t;
endpackage

// File: rtl/ssp_host_fifo.sv
// ssp_host_fifo: power-of-two sync byte FIFO exposing its head and the entry behind it
module ssp_host_fifo
    import ssp_host_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                     clock,
    input  logic                     clear_b,
    input  logic                     push,
    input  logic                     pop,
    input  byte_t                    din,
    output byte_t                    head,
    output byte_t                    head_nx,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    byte_t mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr, rd_nx;
    logic do_push, do_pop;
    assign full    = level == LW'(DEPTH);
    assign empty   = level == '0;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rd_nx   = rd_ptr + AW'(1);
    assign head    = mem[rd_ptr];
    assign head_nx = mem[rd_nx];
    always_ff @(posedge clock)
        if (!clear_b) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop) rd_ptr <= rd_nx;
            level <= level + LW'(do_push) - LW'(do_pop);
        end
    always_ff @(posedge clock)
        if (do_push) mem[wr_ptr] <= din;
endmodule

// File: rtl/ssp_host.sv
// ssp_host: buffers bytes into an SSP TX FIFO and drains its RX FIFO in fixed bursts.
// Define SSP_HOST_STATS_EN to enable the TX_COUNT/RX_COUNT statistics counters.
module ssp_host
    import ssp_host_pkg::*;
#(
    parameter int TXBUF_DEPTH    = 8,
    parameter int SSP_FIFO_DEPTH = 4
) (
    input  logic   PCLK,
    input  logic   CLEAR_B,
    input  logic   LD_VALID,
    input  byte_t  LD_DATA,
    output logic   LD_READY,
    output logic   RD_VALID,
    output byte_t  RD_DATA,
    output logic   PSEL,
    output logic   PWRITE,
    output byte_t  PWDATA,
    input  byte_t  PRDATA,
    input  logic   SSPTXINTR,
    input  logic   SSPRXINTR,
    output count_t TX_COUNT,
    output count_t RX_COUNT
);
    localparam int LW = $clog2(TXBUF_DEPTH) + 1;
    localparam int BW = $clog2(SSP_FIFO_DEPTH) + 1;
    state_t state, nxt;
    byte_t head, head_nx, pwdata_d;
    logic full, empty, wr_ok, remain, last_beat;
    logic [LW-1:0] level;
    logic [BW-1:0] beat;
    assign wr_ok     = state == WRITE && !SSPTXINTR;
    assign remain    = level > LW'(wr_ok);
    assign last_beat = beat == BW'(SSP_FIFO_DEPTH - 1);
    assign LD_READY  = !full;
    ssp_host_fifo #(.DEPTH(TXBUF_DEPTH)) u_fifo (
        .clock   (PCLK),
        .clear_b (CLEAR_B),
        .push    (LD_VALID),
        .pop     (wr_ok),
        .din     (LD_DATA),
        .head    (head),
        .head_nx (head_nx),
        .full    (full),
        .empty   (empty),
        .level   (level)
    );
    always_ff @(posedge PCLK)
        state <= !CLEAR_B ? IDLE : nxt;
    // Outputs are registered from the next state, so PWDATA must already show the post-pop head
    always_comb begin
        nxt = state == READ ? (!last_beat ? READ : empty ? IDLE : WRITE)
            : SSPRXINTR ? READ
            : (state == WRITE ? remain : !empty) ? WRITE : IDLE;
        pwdata_d = nxt == WRITE ? (wr_ok ? head_nx : head) : '0;
    end
    always_ff @(posedge PCLK)
        if (!CLEAR_B) begin
            beat     <= '0;
            PSEL     <= 1'b0;
            PWRITE   <= 1'b0;
            PWDATA   <= '0;
            RD_VALID <= 1'b0;
            RD_DATA  <= '0;
        end else begin
            beat     <= state == READ ? beat + BW'(1) : '0;
            PSEL     <= nxt != IDLE;
            PWRITE   <= nxt == WRITE;
            PWDATA   <= pwdata_d;
            RD_VALID <= state == READ;
            if (state == READ) RD_DATA <= PRDATA;
        end
`ifdef SSP_HOST_STATS_EN
    count_t tx_cnt, rx_cnt;
    always_ff @(posedge PCLK)
        if (!CLEAR_B) begin
            tx_cnt <= '0;
            rx_cnt <= '0;
        end else begin
            tx_cnt <= tx_cnt + count_t'(wr_ok);
            rx_cnt <= rx_cnt + count_t'(state == READ);
        end
    assign TX_COUNT = tx_cnt;
    assign RX_COUNT = rx_cnt;
`else
    assign TX_COUNT = '0;
    assign RX_COUNT = '0;
`endif
endmodule
